gfx_wbm_read: RTL and testbench
===============================

# gfx_wbm_read

Wishbone classic-cycle read master for the GFX accelerator. Accepts one single-word read request at a time from the read arbiter (request/address/select in, data/ack out), runs one classic Wishbone read cycle on the memory bus, and returns the registered read data with a one-cycle acknowledge. It is the slave-side endpoint of the arbiter's request/ack interface.

## Interface
- TIMEOUT_CYCLES, 1024: bus cycles in BUS before abort. Used only with GFX_WBM_READ_TIMEOUT_EN. Minimum 2.
- clk_i  in  1  system clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- read_request_i  in  1  level request from arbiter; held until ack_o
- addr_i  in  30  word address [31:2]
- sel_i  in  4  byte selects
- dat_o  out  32  read data; valid when ack_o is high
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with ack_o on bus error or timeout
- busy_o  out  1  high in BUS and DONE
- cyc_o, stb_o  out  1  Wishbone cycle/strobe
- we_o  out  1  constant 0
- cti_o  out  3  constant 3'b000 (classic)
- bte_o  out  2  constant 2'b00
- adr_o  out  32  {addr latched, 2'b00}
- sel_o  out  4  latched byte selects
- dat_i  in  32  Wishbone read data
- ack_i, err_i  in  1  Wishbone termination

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE: if read_request_i, latch addr_i/sel_i into adr_o/sel_o, assert cyc_o/stb_o, go BUS. Otherwise stay.
- BUS: cyc_o/stb_o held high; adr_o/sel_o stable. Changes on addr_i/sel_i are ignored.
  - err_i: drop cyc/stb, dat_o <= 0, ack_o and err_o pulse next cycle, go DONE.
  - else ack_i: drop cyc/stb, dat_o <= dat_i, ack_o pulse next cycle, go DONE.
  - err_i and ack_i together: err wins.
- DONE: ack_o high for exactly this cycle; read_request_i is ignored (recovery cycle so the requester can deassert); go IDLE.
- dat_o holds its value until the next completion.
- ack_i/err_i outside BUS: ignored.
- read_request_i dropped while in BUS: the cycle still completes and ack_o still pulses. The arbiter must tolerate an unexpected ack.
- Reset: synchronous; outputs after the reset edge are cyc_o=stb_o=ack_o=err_o=busy_o=0, adr_o=0, sel_o=0, dat_o=0, state IDLE. Reset mid-BUS aborts the bus cycle with no ack_o.

## Timing
- Request high at edge 0 (IDLE) -> cyc_o/stb_o high after edge 0.
- Slave ack_i sampled at edge k -> ack_o/dat_o valid after edge k (DONE), back to IDLE after edge k+1.
- Zero-wait slave: ack_o 2 cycles after request is sampled. Earliest next cyc_o is 3 cycles after the previous ack_o rises.
- Throughput: at most one word per 3 cycles.

## Configuration
- GFX_WBM_READ_TIMEOUT_EN defined:
  - A counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no ack_i/err_i: drop cyc/stb, dat_o <= 0, pulse ack_o and err_o, go DONE.
  - ack_i or err_i on the terminal cycle takes priority over the timeout.
- Undefined: no counter; BUS waits indefinitely; err_o only from err_i.

## Structure
- Shared package gfx_wbm_pkg: FSM state typedef (IDLE/BUS/DONE), WB_CTI_CLASSIC=3'b000, WB_BTE_LINEAR=2'b00.
- Optional sub-module gfx_wbm_read_timeout (counter + terminal flag), instantiated only under GFX_WBM_READ_TIMEOUT_EN.

## Test plan
- Basic read: request addr 30'h0000_0100, sel 4'hF; slave acks after 3 waits with 32'hDEADBEEF -> adr_o=32'h0000_0400, one-cycle ack_o, dat_o=32'hDEADBEEF, err_o=0.
- Back-to-back: request held across the ack cycle, then a new address -> no duplicate bus cycle in DONE; second cyc_o rises exactly 3 cycles after the first ack_o.
- Bus error: err_i and ack_i asserted together -> ack_o and err_o pulse, dat_o=0.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never acks -> cyc_o drops after 8 BUS cycles, ack_o and err_o pulse. Macro off: cyc_o stays high for 100+ cycles.
- Reset mid-BUS: assert rst_i for 1 cycle during wait states -> cyc_o=0 and all outputs 0 the next cycle, no ack_o, and a new request is then served normally.
- Mid-cycle input change: addr_i/sel_i change while in BUS -> adr_o/sel_o unchanged until completion.

Source files
------------

// File: rtl/gfx_wbm_pkg.sv
// Shared definitions for the GFX Wishbone master blocks.
package gfx_wbm_pkg;

    // Read master FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StDone = 2'd2
    } wbm_state_e;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/gfx_wbm_read_timeout.sv
// Bus-cycle timeout counter for gfx_wbm_read.
// terminal is high on the cycle where the count has reached TIMEOUT_CYCLES-1.
module gfx_wbm_read_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TermVal = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q;

    // Count cycles spent in BUS; cleared on entry to BUS.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (count_en && (count_q != TermVal)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Terminal flag for the current count value.
    always_comb begin
        terminal = (count_q == TermVal);
    end

endmodule

// File: rtl/gfx_wbm_read.sv
// Wishbone classic-cycle single-word read master for the GFX accelerator.
// Optional bus timeout enabled by defining GFX_WBM_READ_TIMEOUT_EN.
module gfx_wbm_read
    import gfx_wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // Arbiter side
    input  logic        read_request_i,
    input  logic [29:0] addr_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o,
    // Wishbone side
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("gfx_wbm_read: TIMEOUT_CYCLES must be at least 2");
    end

    wbm_state_e  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic        err_q, err_d;
    logic        timeout_hit;

`ifdef GFX_WBM_READ_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_count_en;

    // Clear the counter on the IDLE->BUS transition, count while in BUS.
    always_comb begin
        tmo_clear    = (state_q == StIdle) && read_request_i;
        tmo_count_en = (state_q == StBus);
    end

    gfx_wbm_read_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (tmo_clear),
        .count_en (tmo_count_en),
        .terminal (timeout_hit)
    );
`else
    // No timeout: BUS waits for the slave indefinitely.
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Next-state and datapath updates; err/ack win over the timeout.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (read_request_i) begin
                    adr_d   = {addr_i, 2'b00};
                    sel_d   = sel_i;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (err_i) begin
                    dat_d   = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (ack_i) begin
                    dat_d   = dat_i;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    dat_d   = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            // Recovery cycle: request ignored so the arbiter can deassert.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state, so they are glitch-free.
    always_comb begin
        cyc_o  = (state_q == StBus);
        stb_o  = (state_q == StBus);
        ack_o  = (state_q == StDone);
        busy_o = (state_q == StBus) || (state_q == StDone);
        err_o  = err_q;
        dat_o  = dat_q;
        adr_o  = adr_q;
        sel_o  = sel_q;
        we_o   = 1'b0;
        cti_o  = WB_CTI_CLASSIC;
        bte_o  = WB_BTE_LINEAR;
    end

endmodule

// File: tb/tb_gfx_wbm_read.sv
// Self-checking bench for gfx_wbm_read (table-driven reads plus corner sequences).
// Honours GFX_WBM_READ_TIMEOUT_EN to select the timeout expectations.
module tb_gfx_wbm_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_request;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack_o, err_o, busy_o;
    logic        cyc_o, stb_o, we_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] prev_dat;

    always #5 clk = ~clk;

    gfx_wbm_read #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .read_request_i (read_request),
        .addr_i         (addr),
        .sel_i          (sel),
        .dat_o          (dat_o),
        .ack_o          (ack_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .cyc_o          (cyc_o),
        .stb_o          (stb_o),
        .we_o           (we_o),
        .cti_o          (cti_o),
        .bte_o          (bte_o),
        .adr_o          (adr_o),
        .sel_o          (sel_o),
        .dat_i          (dat_i),
        .ack_i          (ack_i),
        .err_i          (err_i)
    );

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  sel;
        logic [7:0]  waits;
        logic [31:0] rdata;
        logic        ack;
        logic        err;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete read; addr_i/sel_i are scrambled while BUS is active.
    task automatic read_txn(input int idx, input vec_t v);
        logic unstable;
        unstable     = 1'b0;
        read_request = 1'b1;
        addr         = v.addr;
        sel          = v.sel;
        step();
        check($sformatf("v%0d cyc_rise", idx), {31'b0, cyc_o & stb_o}, 32'd1);
        check($sformatf("v%0d adr_o", idx), adr_o, v.exp_adr);
        check($sformatf("v%0d sel_o", idx), {28'b0, sel_o}, {28'b0, v.sel});
        addr  = ~v.addr;
        sel   = ~v.sel;
        dat_i = 32'hFFFF_0000;
        for (int w = 0; w < int'(v.waits); w++) begin
            step();
            if (!cyc_o || ack_o || adr_o !== v.exp_adr || sel_o !== v.sel || dat_o !== prev_dat)
                unstable = 1'b1;
        end
        check($sformatf("v%0d bus_stable", idx), {31'b0, unstable}, 32'd0);
        dat_i = v.rdata;
        ack_i = v.ack;
        err_i = v.err;
        step();
        ack_i        = 1'b0;
        err_i        = 1'b0;
        read_request = 1'b0;
        check($sformatf("v%0d ack_o", idx), {31'b0, ack_o}, 32'd1);
        check($sformatf("v%0d err_o", idx), {31'b0, err_o}, {31'b0, v.exp_err});
        check($sformatf("v%0d dat_o", idx), dat_o, v.exp_dat);
        check($sformatf("v%0d cyc_drop", idx), {31'b0, cyc_o}, 32'd0);
        step();
        check($sformatf("v%0d ack_pulse", idx), {29'b0, ack_o, err_o, busy_o}, 32'd0);
        check($sformatf("v%0d dat_hold", idx), dat_o, v.exp_dat);
        prev_dat = v.exp_dat;
    endtask

    initial begin
        int n_bus;
        int n_low;
        logic [31:0] ack_time;

        //            addr           sel   waits rdata          ack   err   exp_adr        exp_dat        exp_err
        vecs[0] = '{30'h0000_0100, 4'hF, 8'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{30'h0000_002A, 4'hC, 8'd2, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0000_00A8, 32'h0000_0000, 1'b1};
        vecs[2] = '{30'h3FFF_FFFF, 4'h1, 8'd0, 32'h1234_5678, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0};
        vecs[3] = '{30'h0000_0055, 4'h3, 8'd1, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0000_0154, 32'h0000_0000, 1'b1};
        vecs[4] = '{30'h0000_0000, 4'h6, 8'd5, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};

        rst          = 1'b1;
        read_request = 1'b0;
        addr         = 30'h1555_5555;
        sel          = 4'hA;
        dat_i        = '0;
        ack_i        = 1'b0;
        err_i        = 1'b0;
        prev_dat     = '0;
        step();
        step();
        check("rst_ctrl", {27'b0, cyc_o, stb_o, ack_o, err_o, busy_o}, 32'd0);
        check("rst_adr", adr_o, 32'd0);
        check("rst_sel_dat", {28'b0, sel_o} | dat_o, 32'd0);
        check("const_we_cti_bte", {26'b0, we_o, cti_o, bte_o}, 32'd0);
        rst = 1'b0;

        // Slave termination while idle must be ignored.
        ack_i = 1'b1;
        err_i = 1'b1;
        step();
        ack_i = 1'b0;
        err_i = 1'b0;
        step();
        check("idle_ack_ignored", {29'b0, ack_o, err_o, cyc_o}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            read_txn(i, vecs[i]);
        end

        // Back-to-back: request held through ack and DONE with a new address.
        read_request = 1'b1;
        addr         = 30'h0000_0200;
        sel          = 4'hF;
        step();
        dat_i = 32'h1111_2222;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        addr  = 30'h0000_0300;
        sel   = 4'h5;
        check("b2b_ack1", {31'b0, ack_o}, 32'd1);
        check("b2b_dat1", dat_o, 32'h1111_2222);
        check("b2b_no_dup_in_done", {31'b0, cyc_o}, 32'd0);
        ack_time = 0;
        n_bus    = 0;
        // cyc_o is expected two edges after ack_o rose (third cycle counting the ack cycle).
        while (!cyc_o && n_bus < 10) begin
            step();
            n_bus++;
        end
        check("b2b_cyc_gap_edges", n_bus, 32'd2);
        check("b2b_adr2", adr_o, 32'h0000_0C00);
        check("b2b_sel2", {28'b0, sel_o}, 32'h5);
        dat_i = 32'h3333_4444;
        ack_i = 1'b1;
        step();
        ack_i        = 1'b0;
        read_request = 1'b0;
        check("b2b_dat2", dat_o, 32'h3333_4444);
        step();
        step();

        // Reset during wait states aborts the cycle without an ack.
        read_request = 1'b1;
        addr         = 30'h0000_0777;
        sel          = 4'h9;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ctrl", {27'b0, cyc_o, stb_o, ack_o, err_o, busy_o}, 32'd0);
        check("midrst_adr_sel_dat", adr_o | {28'b0, sel_o} | dat_o, 32'd0);
        read_request = 1'b0;
        ack_i        = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        check("midrst_no_ack", {30'b0, ack_o, cyc_o}, 32'd0);
        prev_dat = '0;
        read_txn(9, vecs[0]);

        // Slave that never terminates.
        read_request = 1'b1;
        addr         = 30'h0000_0040;
        sel          = 4'hF;
        step();
        n_bus = 1;
`ifdef GFX_WBM_READ_TIMEOUT_EN
        while (cyc_o && n_bus < 50) begin
            step();
            if (cyc_o) n_bus++;
        end
        read_request = 1'b0;
        check("tmo_bus_cycles", n_bus, 32'd8);
        check("tmo_ack_err", {30'b0, ack_o, err_o}, 32'd3);
        check("tmo_dat", dat_o, 32'd0);
        step();
        check("tmo_pulse_end", {29'b0, ack_o, err_o, busy_o}, 32'd0);
`else
        n_low = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (!cyc_o || ack_o) n_low++;
        end
        check("notmo_cyc_held", n_low, 32'd0);
        dat_i = 32'h5A5A_0001;
        ack_i = 1'b1;
        step();
        ack_i        = 1'b0;
        read_request = 1'b0;
        check("notmo_late_ack", {30'b0, ack_o, err_o}, 32'd2);
        check("notmo_dat", dat_o, 32'h5A5A_0001);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
